alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised EX-stage ALU for the MIPS pipeline: decodes ALUop/Funct into a 4-bit control
//  code, executes single-cycle ops with registered output, and runs MULT/MULTU/DIV/DIVU
//  iteratively into HI/LO with a busy stall to the hazard unit. Sits between ID/EX and EX/MEM.
// PARAMETERS
//  WIDTH      32  datapath width (>=8, even)
//  MD_ENABLE  1   1: mult/div/mfhi/mflo implemented; 0: those functs decode as illegal
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  in_valid     in   1      op presented this cycle
//  alu_op       in   2      0=ADD, 1=SUB, 2=R-type (use funct), 3=illegal
//  funct        in   6      R-type function field
//  op_a, op_b   in   WIDTH  operands (rs, rt/imm)
//  busy         out  1      mult/div in progress; upstream must hold and stall
//  res_valid    out  1      result/zero/ctrl_code valid this cycle
//  result       out  WIDTH  registered result
//  zero         out  1      result == 0
//  ctrl_code    out  4      decoded code: 2 ADD, 6 SUB, 0 AND, 1 OR, 7 SLT, 8 MD, 9 MFHI, A MFLO
//  illegal      out  1      decode failed for the accepted op (pulse with res_valid)
//  md_done      out  1      one-cycle pulse when HI/LO updated
//  hi, lo       out  WIDTH  HI/LO architectural registers
// BEHAVIOUR
//  Reset: all outputs 0; HI=LO=0; FSM IDLE. Reset mid-op aborts; HI/LO return to 0.
//  Accept: in_valid && !busy. in_valid while busy is ignored (no side effect).
//  Decode funct: 32 ADD, 34 SUB, 36 AND, 37 OR, 42 SLT (signed), 24 MULT, 25 MULTU,
//   26 DIV, 27 DIVU, 16 MFHI, 18 MFLO. Others / alu_op=3: illegal=1, result=0, ctrl_code=F.
//   Illegal never holds a stale code.
//  Single-cycle ops (ADD/SUB/AND/OR/SLT/MFHI/MFLO/illegal): latency 1; res_valid high the
//   cycle after accept. ADD/SUB wrap modulo 2^WIDTH, no overflow trap. SLT -> 1 or 0.
//  MFHI/MFLO read HI/LO as of accept edge; cannot overlap an active mult/div (busy blocks).
//  Mult/div: FSM IDLE->RUN->FIX->IDLE. Accept: load magnitudes (signed ops take |x|,
//   record signs), busy=1 next cycle. RUN: WIDTH iterations, one bit/cycle (shift-add
//   multiply, restoring divide). FIX: apply signs, write {HI,LO}, md_done=1, busy=0 same
//   cycle. Total busy = WIDTH+1 cycles; res_valid stays 0 (no GPR writeback).
//  Signed mult: 2W-bit two's-complement product; HI=upper, LO=lower.
//  Div: LO=quotient (truncate toward 0), HI=remainder (sign of dividend).
//  Div by zero: still WIDTH+1 cycles; LO={WIDTH{1}}, HI=op_a; no flag.
//  Signed MIN/-1: LO=MIN, HI=0 (no trap).
//  zero mirrors result, qualified only by res_valid.
// STRUCTURE
//  alu_pkg: alu_op encodings, funct constants, ctrl_code constants, md FSM state enum.
//  Sub-module md_iter: iterative mult/div datapath + FSM (ports: start, is_div, is_signed,
//   a, b -> busy, done, hi_out, lo_out). Top holds decode, single-cycle ALU, HI/LO, regs.
// TESTING
//  ADD 5+7 -> next cycle res_valid=1, result=12, ctrl_code=2, zero=0; SUB 7-7 -> 0, zero=1.
//  R-type SLT a=-1,b=1 -> 1; AND/OR F0F0,0FF0 -> 00F0/FFF0; funct=63 -> illegal=1, result=0.
//  MULT -3*5 (WIDTH=32) -> busy 33 cycles, md_done; HI=FFFFFFFF, LO=FFFFFFF1; MFLO -> FFFFFFF1.
//  DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF; DIVU 7/0 -> LO=FFFFFFFF, HI=7.
//  in_valid ADD during busy -> ignored, no res_valid; retried after md_done -> correct.
//  Assert rst_n low mid-DIV -> busy=0, HI=LO=0 at once; WIDTH=16 rerun MULTU FFFF*FFFF -> HI=FFFE, LO=0001.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings, decode function and mult/div state enum for the EX-stage ALU
package alu_pkg;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_SUB   = 2'd1;
  localparam logic [1:0] ALU_OP_RTYPE = 2'd2;
  localparam logic [1:0] ALU_OP_ILL   = 2'd3;

  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;

  localparam logic [3:0] CTRL_AND  = 4'h0;
  localparam logic [3:0] CTRL_OR   = 4'h1;
  localparam logic [3:0] CTRL_ADD  = 4'h2;
  localparam logic [3:0] CTRL_SUB  = 4'h6;
  localparam logic [3:0] CTRL_SLT  = 4'h7;
  localparam logic [3:0] CTRL_MD   = 4'h8;
  localparam logic [3:0] CTRL_MFHI = 4'h9;
  localparam logic [3:0] CTRL_MFLO = 4'hA;
  localparam logic [3:0] CTRL_ILL  = 4'hF;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       ill;
    logic       md;
    logic       md_div;
    logic       md_signed;
  } dec_t;

  // Every path starts from the illegal encoding so a failed decode can never carry a stale code.
  function automatic dec_t decode(input logic [1:0] alu_op, input logic [5:0] funct,
                                  input bit md_en);
    dec_t d;
    d.ctrl      = CTRL_ILL;
    d.ill       = 1'b1;
    d.md        = 1'b0;
    d.md_div    = 1'b0;
    d.md_signed = 1'b0;
    case (alu_op)
      ALU_OP_ADD: begin d.ctrl = CTRL_ADD; d.ill = 1'b0; end
      ALU_OP_SUB: begin d.ctrl = CTRL_SUB; d.ill = 1'b0; end
      ALU_OP_RTYPE: begin
        case (funct)
          FN_ADD: begin d.ctrl = CTRL_ADD; d.ill = 1'b0; end
          FN_SUB: begin d.ctrl = CTRL_SUB; d.ill = 1'b0; end
          FN_AND: begin d.ctrl = CTRL_AND; d.ill = 1'b0; end
          FN_OR:  begin d.ctrl = CTRL_OR;  d.ill = 1'b0; end
          FN_SLT: begin d.ctrl = CTRL_SLT; d.ill = 1'b0; end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            if (md_en) begin
              d.ctrl      = CTRL_MD;
              d.ill       = 1'b0;
              d.md        = 1'b1;
              d.md_div    = (funct == FN_DIV) || (funct == FN_DIVU);
              d.md_signed = (funct == FN_MULT) || (funct == FN_DIV);
            end
          end
          FN_MFHI: if (md_en) begin d.ctrl = CTRL_MFHI; d.ill = 1'b0; end
          FN_MFLO: if (md_en) begin d.ctrl = CTRL_MFLO; d.ill = 1'b0; end
          default: d.ill = 1'b1;
        endcase
      end
      ALU_OP_ILL: d.ill = 1'b1;
      default:    d.ill = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/md_iter.sv
// rtl/md_iter.sv - iterative multiply/divide datapath: one bit per cycle on magnitudes, signs fixed at the end
module md_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e        state;
  logic [CW-1:0]    cnt;
  logic             div_q, neg_res, neg_rem, div_zero;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo, opnd, a_raw;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // acc_hi is one bit wider so the multiply partial sum keeps its carry before the shift.
  assign mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      div_q    <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      a_raw    <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state    <= MD_RUN;
            cnt      <= '0;
            div_q    <= is_div;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= is_div && (b == '0);
            a_raw    <= a;
            acc_hi   <= '0;
            acc_lo   <= is_div ? a_mag : b_mag;
            opnd     <= is_div ? b_mag : a_mag;
          end
        end
        MD_RUN: begin
          if (div_q) begin
            if (!div_trial[WIDTH]) begin
              acc_hi <= {1'b0, div_trial[WIDTH-1:0]};
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= {1'b0, div_shift[WIDTH-1:0]};
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= {1'b0, mul_sum[WIDTH:1]};
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= MD_FIX;
        end
        MD_FIX:  state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  always_comb begin
    busy   = (state != MD_IDLE);
    done   = (state == MD_FIX);
    prod   = {acc_hi[WIDTH-1:0], acc_lo};
    prod_s = neg_res ? -prod : prod;
    quo_s  = neg_res ? -acc_lo : acc_lo;
    rem_s  = neg_rem ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    hi_out = prod_s[2*WIDTH-1:WIDTH];
    lo_out = prod_s[WIDTH-1:0];
    // Divide by zero bypasses the sign fix so HI returns the dividend untouched.
    if (div_q) begin
      if (div_zero) begin
        hi_out = a_raw;
        lo_out = '1;
      end else begin
        hi_out = rem_s;
        lo_out = quo_s;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU: decode, single-cycle ops with registered result, HI/LO and mult/div stall
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MD_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       ctrl_code,
  output logic             illegal,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  dec_t             dec;
  logic             accept, md_fin;
  logic [WIDTH-1:0] alu_res, md_hi, md_lo;

  assign dec    = decode(alu_op, funct, MD_ENABLE);
  assign accept = in_valid & ~busy;

  always_comb begin
    alu_res = '0;
    case (dec.ctrl)
      CTRL_ADD:  alu_res = op_a + op_b;
      CTRL_SUB:  alu_res = op_a - op_b;
      CTRL_AND:  alu_res = op_a & op_b;
      CTRL_OR:   alu_res = op_a | op_b;
      CTRL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      CTRL_MFHI: alu_res = hi;
      CTRL_MFLO: alu_res = lo;
      default:   alu_res = '0;
    endcase
  end

  md_iter #(.WIDTH(WIDTH)) u_md_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept & dec.md),
    .is_div    (dec.md_div),
    .is_signed (dec.md_signed),
    .a         (op_a),
    .b         (op_b),
    .busy      (busy),
    .done      (md_fin),
    .hi_out    (md_hi),
    .lo_out    (md_lo)
  );

  // Mult/div never writes back a GPR, so only single-cycle accepts raise res_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ctrl_code <= '0;
      illegal   <= 1'b0;
      md_done   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      res_valid <= accept & ~dec.md;
      illegal   <= accept & dec.ill;
      md_done   <= md_fin;
      if (accept && !dec.md) begin
        result    <= alu_res;
        zero      <= (alu_res == '0);
        ctrl_code <= dec.ctrl;
      end
      if (md_fin) begin
        hi <= md_hi;
        lo <= md_lo;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit at WIDTH 32 and 16
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b;
  logic        busy, res_valid, zero, illegal, md_done;
  logic [31:0] result, hi, lo;
  logic [3:0]  ctrl_code;

  logic        in_valid16;
  logic [1:0]  alu_op16;
  logic [5:0]  funct16;
  logic [15:0] op_a16, op_b16;
  logic        busy16, res_valid16, zero16, illegal16, md_done16;
  logic [15:0] result16, hi16, lo16;
  logic [3:0]  ctrl_code16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(32), .MD_ENABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_op(alu_op), .funct(funct),
    .op_a(op_a), .op_b(op_b), .busy(busy), .res_valid(res_valid), .result(result),
    .zero(zero), .ctrl_code(ctrl_code), .illegal(illegal), .md_done(md_done),
    .hi(hi), .lo(lo)
  );

  alu_exec_unit #(.WIDTH(16), .MD_ENABLE(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .alu_op(alu_op16), .funct(funct16),
    .op_a(op_a16), .op_b(op_b16), .busy(busy16), .res_valid(res_valid16), .result(result16),
    .zero(zero16), .ctrl_code(ctrl_code16), .illegal(illegal16), .md_done(md_done16),
    .hi(hi16), .lo(lo16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x,
                       input logic [31:0] y);
    alu_op = op; funct = f; op_a = x; op_b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Runs one mult/div; optionally holds an ADD on in_valid for the whole busy window.
  task automatic md_run(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                        input bit poke, output int n, output bit saw_rv);
    issue(ALU_OP_RTYPE, f, x, y);
    n = 0;
    saw_rv = 1'b0;
    if (poke) begin
      alu_op = ALU_OP_ADD; funct = 6'd0; op_a = 32'd1; op_b = 32'd2; in_valid = 1'b1;
    end
    while (busy && n < 100) begin
      n++;
      if (res_valid) saw_rv = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (res_valid) saw_rv = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [31:0] a, b, res;
    logic [3:0]  cc;
    logic        ill;
  } vec_t;

  vec_t vecs[10];
  int   n;
  bit   saw_rv;

  initial begin
    vecs[0] = '{ALU_OP_ADD,   6'd0,   32'd5,        32'd7,        32'd12,       4'h2, 1'b0};
    vecs[1] = '{ALU_OP_SUB,   6'd0,   32'd7,        32'd7,        32'd0,        4'h6, 1'b0};
    vecs[2] = '{ALU_OP_RTYPE, 6'd42,  32'hFFFFFFFF, 32'd1,        32'd1,        4'h7, 1'b0};
    vecs[3] = '{ALU_OP_RTYPE, 6'd42,  32'd1,        32'hFFFFFFFF, 32'd0,        4'h7, 1'b0};
    vecs[4] = '{ALU_OP_RTYPE, 6'd36,  32'hF0F0,     32'h0FF0,     32'h00F0,     4'h0, 1'b0};
    vecs[5] = '{ALU_OP_RTYPE, 6'd37,  32'hF0F0,     32'h0FF0,     32'hFFF0,     4'h1, 1'b0};
    vecs[6] = '{ALU_OP_RTYPE, 6'd32,  32'hFFFFFFFF, 32'd1,        32'd0,        4'h2, 1'b0};
    vecs[7] = '{ALU_OP_RTYPE, 6'd34,  32'd0,        32'd1,        32'hFFFFFFFF, 4'h6, 1'b0};
    vecs[8] = '{ALU_OP_RTYPE, 6'd63,  32'd3,        32'd4,        32'd0,        4'hF, 1'b1};
    vecs[9] = '{ALU_OP_ILL,   6'd32,  32'd3,        32'd4,        32'd0,        4'hF, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; alu_op = '0; funct = '0; op_a = '0; op_b = '0;
    in_valid16 = 1'b0; alu_op16 = '0; funct16 = '0; op_a16 = '0; op_b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", {res_valid, zero, illegal, md_done, busy, ctrl_code}, '0);
    check("reset_result", result, '0);
    check("reset_hilo", {hi, lo}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d", i), {res_valid, zero, illegal, ctrl_code, result},
            {1'b1, (vecs[i].res == 32'd0), vecs[i].ill, vecs[i].cc, vecs[i].res});
    end
    @(posedge clk); #1;
    check("idle_no_valid", {res_valid, illegal}, 2'b00);

    md_run(FN_MULT, 32'hFFFFFFFD, 32'd5, 1'b1, n, saw_rv);
    check("mult_busy_cycles", n, 33);
    check("mult_done", md_done, 1'b1);
    check("mult_ignored_add", saw_rv, 1'b0);
    check("mult_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF1});

    issue(ALU_OP_ADD, 6'd0, 32'd1, 32'd2);
    check("retry_add", {res_valid, ctrl_code, result}, {1'b1, 4'h2, 32'd3});
    issue(ALU_OP_RTYPE, FN_MFLO, 32'd0, 32'd0);
    check("mflo", {res_valid, ctrl_code, result}, {1'b1, 4'hA, 32'hFFFFFFF1});
    issue(ALU_OP_RTYPE, FN_MFHI, 32'd0, 32'd0);
    check("mfhi", {res_valid, ctrl_code, result}, {1'b1, 4'h9, 32'hFFFFFFFF});

    md_run(FN_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, n, saw_rv);
    check("div_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    md_run(FN_DIVU, 32'd7, 32'd0, 1'b0, n, saw_rv);
    check("divu_zero_cycles", n, 33);
    check("divu_zero_hilo", {hi, lo}, {32'd7, 32'hFFFFFFFF});
    md_run(FN_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, n, saw_rv);
    check("div_min_hilo", {hi, lo}, {32'd0, 32'h80000000});
    md_run(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, n, saw_rv);
    check("multu_hilo", {hi, lo}, {32'hFFFFFFFE, 32'h00000001});

    issue(ALU_OP_RTYPE, FN_DIV, 32'd100, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    check("div_running", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_hilo", {hi, lo}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    alu_op16 = ALU_OP_RTYPE; funct16 = FN_MULTU; op_a16 = 16'hFFFF; op_b16 = 16'hFFFF;
    in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    n = 0;
    while (busy16 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("w16_busy_cycles", n, 17);
    check("w16_done", md_done16, 1'b1);
    check("w16_multu_hilo", {hi16, lo16}, {16'hFFFE, 16'h0001});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
